rst_sync_seq: RTL and testbench
===============================

# rst_sync_seq

Parametrised reset synchroniser and release sequencer: synchronises an asynchronous, active-high system reset into the `clk` domain through a configurable-depth flop chain and drives `NUM_CH` per-channel reset outputs. All outputs assert asynchronously. Channels are released one at a time, in ascending index order, after a guaranteed minimum assertion window. An optional synchronous software reset request re-runs the sequence. Sits at the root of each clock domain and feeds router/NoC channel resets.

## Interface
- `NUM_CH`, default 4: number of reset output channels; legal range ≥1.
- `SYNC_STAGES`, default 3: synchroniser depth; legal range ≥2.
- `MIN_ASSERT`, default 16: cycles all channels stay asserted after the synchronised reset deasserts; legal range ≥1.
- `RELEASE_GAP`, default 8: cycles between successive channel releases; legal range ≥1.
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset, asynchronous, active-high. There is one clock, and `rst` asserts asynchronously and deasserts through the synchroniser.
- `sw_rst_req`  in  1  synchronous software reset request, sampled on each posedge (present only with `RST_SYNC_SEQ_SW_REQ_EN`).
- `ch_rst_o`  out  NUM_CH  per-channel reset, active-high.
- `all_released`  out  1  high once every channel is released.
- `busy`  out  1  high whenever the FSM is not in DONE.

## Operation
- Synchroniser: `SYNC_STAGES` flops, async-set to 1 by `rst`, shifting in 0. `rst_sync` is the last stage.
- FSM state is ASSERT, RELEASE or DONE. Async reset value:
  - state = ASSERT, counter = 0, channel index = 0.
  - `ch_rst_o` = all 1s, `all_released` = 0, `busy` = 1.
- ASSERT:
  - While `rst_sync` = 1, the counter holds at 0.
  - Otherwise the counter increments each cycle.
  - On the edge where the counter would reach `MIN_ASSERT`: clear `ch_rst_o[0]`, set index to 1, reset the counter.
  - Then go to RELEASE, or to DONE if `NUM_CH` = 1.
- RELEASE:
  - The counter increments each cycle.
  - On the edge where it would reach `RELEASE_GAP`: clear `ch_rst_o[index]`, increment index, reset the counter.
  - Go to DONE after clearing channel `NUM_CH`-1.
- DONE: holds, with `all_released` = 1 and `busy` = 0.
- Released channels stay released until `rst` or a software request.
- Arithmetic and widths:
  - Counter width is `$clog2(max(MIN_ASSERT,RELEASE_GAP)+1)`; no wrap-around is possible.
  - Index width is `max(1,$clog2(NUM_CH))`.
- Boundary conditions:
  - `rst` asserted in any state: all outputs return to their reset values immediately, without waiting for a clock edge. The full sequence restarts from the synchroniser.
  - A `rst` pulse shorter than one clock period still resets the chain fully.
  - `sw_rst_req` in RELEASE or DONE: at that edge, all `ch_rst_o` go to 1, `all_released` goes to 0, state goes to ASSERT and the counter to 0. The synchroniser is not re-run.
  - `sw_rst_req` in ASSERT: the counter reloads to 0, which extends the window.
  - `sw_rst_req` on the same edge as a scheduled release: the request wins, and no channel is released.
  - `sw_rst_req` while `rst_sync` = 1: no additional effect.

## Timing
- Number edges 1, 2, … starting with the first posedge after `rst` falls.
  - `rst_sync` = 0 after edge `SYNC_STAGES`.
  - `ch_rst_o[k]` falls at edge `SYNC_STAGES + MIN_ASSERT + k*RELEASE_GAP`.
  - `all_released` rises on the same edge as the last channel falls.
- After a software request sampled at edge S: `ch_rst_o[k]` falls at edge `S + MIN_ASSERT + k*RELEASE_GAP`.
- All outputs are registered; no combinational path from any input to any output except the asynchronous `rst` assertion.

## Configuration
- `RST_SYNC_SEQ_SW_REQ_EN` defined:
  - the `sw_rst_req` port exists;
  - the software-request behaviour applies.
- Not defined:
  - the port is absent;
  - the request is internally tied to 0;
  - only `rst` restarts the sequence.

## Structure
- Shared package `rst_sync_seq_pkg` holds:
  - the FSM state enum typedef (ASSERT, RELEASE, DONE);
  - the default parameter constants.
- Sub-module `rst_sync_chain` (parameter `SYNC_STAGES`) is the async-set synchroniser. The FSM, counters and output registers live in the top module.

## Test plan
- Defaults, release `rst` → `ch_rst_o` falls at edges 19, 27, 35 and 43 for channels 0–3; `all_released` rises at edge 43; `busy` falls at edge 43.
- Assert `rst` mid-RELEASE, between edges 30 and 31 → `ch_rst_o` goes to 0xF with no clock edge needed. After release, timing repeats exactly as in the previous scenario.
- `sw_rst_req` pulse at edge 60 in DONE → `ch_rst_o` = 0xF at edge 60; channel 0 falls at edge 76, channel 3 at edge 100.
- `sw_rst_req` at edge 27, coinciding with the channel 1 release → channel 1 stays asserted; channel 0 re-asserts at edge 27; channel 0 falls at edge 43.
- Edge-case configuration (`NUM_CH`=1, `SYNC_STAGES`=2, `MIN_ASSERT`=1) → `ch_rst_o[0]` and `all_released` change at edge 3.
- Build without `RST_SYNC_SEQ_SW_REQ_EN` → the port is absent, and the sequence matches the first scenario.

Source files
------------

// File: rtl/rst_sync_seq_pkg.sv
// ----------------------------------------------------------------------------
// rst_sync_seq_pkg
//
// Shared definitions for the reset synchroniser / release sequencer:
//   - state_e     : sequencer FSM states (ASSERT, RELEASE, DONE)
//   - DEF_*       : default values for the top-level parameters
//   - maxInt()    : elaboration-time helper for sizing counters
// ----------------------------------------------------------------------------
package rst_sync_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_SYNC_STAGES = 3;
    localparam int DEF_MIN_ASSERT  = 16;
    localparam int DEF_RELEASE_GAP = 8;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// ----------------------------------------------------------------------------
// rst_sync_chain
//
// Asynchronous-assert / synchronous-deassert reset synchroniser. Every stage
// is set to 1 immediately by rst_i and a 0 is shifted in from the front, so
// the output falls SYNC_STAGES clock edges after rst_i is released. A pulse
// on rst_i of any width sets the whole chain.
//
// Ports:
//   clk_i       clock of the destination domain
//   rst_i       asynchronous active-high reset
//   rst_sync_o  synchronised reset (last stage of the chain)
// ----------------------------------------------------------------------------
module rst_sync_chain #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic rst_sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift register: bit 0 is the first stage, bit SYNC_STAGES-1 the output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sync_seq.sv
// ----------------------------------------------------------------------------
// rst_sync_seq
//
// Reset synchroniser and release sequencer. The system reset is synchronised
// into the clk domain, all channel resets are held for MIN_ASSERT cycles after
// the synchronised reset falls, and then channels are released one at a time
// in ascending order, RELEASE_GAP cycles apart.
//
// Ports:
//   clk           single clock for the block
//   rst           asynchronous active-high reset (asserts all outputs at once)
//   sw_rst_req    synchronous software request to re-run the sequence
//                 (only present when RST_SYNC_SEQ_SW_REQ_EN is defined)
//   ch_rst_o      per-channel active-high resets
//   all_released  high once every channel has been released
//   busy          high whenever the sequencer is not in DONE
//
// Build option:
//   RST_SYNC_SEQ_SW_REQ_EN  adds the sw_rst_req port; without it only rst
//                           restarts the sequence.
// ----------------------------------------------------------------------------
module rst_sync_seq
    import rst_sync_seq_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MIN_ASSERT  = DEF_MIN_ASSERT,
    parameter int RELEASE_GAP = DEF_RELEASE_GAP
) (
    input  logic              clk,
    input  logic              rst,
`ifdef RST_SYNC_SEQ_SW_REQ_EN
    input  logic              sw_rst_req,
`endif
    output logic [NUM_CH-1:0] ch_rst_o,
    output logic              all_released,
    output logic              busy
);

    localparam int CNT_W = $clog2(maxInt(MIN_ASSERT, RELEASE_GAP) + 1);
    localparam int IDX_W = maxInt(1, $clog2(NUM_CH));

    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_ASSERT);
    localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(RELEASE_GAP);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    logic              rstSync;
    logic              swReq;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cntInc;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] chRst_q, chRst_d;
    logic              allReleased_q, allReleased_d;
    logic              busy_q, busy_d;

    rst_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i      (clk),
        .rst_i      (rst),
        .rst_sync_o (rstSync)
    );

`ifdef RST_SYNC_SEQ_SW_REQ_EN
    assign swReq = sw_rst_req;
`else
    assign swReq = 1'b0;
`endif

    assign cntInc = cnt_q + 1'b1;

    // Next-state logic. A software request takes priority over any release
    // scheduled on the same edge, and in ASSERT it simply restarts the window.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        chRst_d       = chRst_q;
        allReleased_d = allReleased_q;
        busy_d        = busy_q;

        case (state_q)
            ASSERT: begin
                if (rstSync || swReq) begin
                    cnt_d = '0;
                end else if (cntInc == MIN_CNT) begin
                    chRst_d[0] = 1'b0;
                    idx_d      = IDX_W'(1);
                    cnt_d      = '0;
                    if (NUM_CH == 1) begin
                        state_d       = DONE;
                        allReleased_d = 1'b1;
                        busy_d        = 1'b0;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cntInc;
                end
            end

            RELEASE: begin
                if (swReq) begin
                    state_d       = ASSERT;
                    cnt_d         = '0;
                    idx_d         = '0;
                    chRst_d       = '1;
                    allReleased_d = 1'b0;
                    busy_d        = 1'b1;
                end else if (cntInc == GAP_CNT) begin
                    chRst_d[idx_q] = 1'b0;
                    idx_d          = idx_q + 1'b1;
                    cnt_d          = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d       = DONE;
                        allReleased_d = 1'b1;
                        busy_d        = 1'b0;
                    end
                end else begin
                    cnt_d = cntInc;
                end
            end

            DONE: begin
                if (swReq) begin
                    state_d       = ASSERT;
                    cnt_d         = '0;
                    idx_d         = '0;
                    chRst_d       = '1;
                    allReleased_d = 1'b0;
                    busy_d        = 1'b1;
                end
            end

            default: begin
                state_d       = ASSERT;
                cnt_d         = '0;
                idx_d         = '0;
                chRst_d       = '1;
                allReleased_d = 1'b0;
                busy_d        = 1'b1;
            end
        endcase
    end

    // State and output registers. The raw rst (not the synchronised one)
    // clears them so every output asserts without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ASSERT;
            cnt_q         <= '0;
            idx_q         <= '0;
            chRst_q       <= '1;
            allReleased_q <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            chRst_q       <= chRst_d;
            allReleased_q <= allReleased_d;
            busy_q        <= busy_d;
        end
    end

    assign ch_rst_o     = chRst_q;
    assign all_released = allReleased_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_rst_sync_seq.sv
// ----------------------------------------------------------------------------
// tb_rst_sync_seq
//
// Directed bench for rst_sync_seq: a default-parameter instance and a
// minimal instance (NUM_CH=1, SYNC_STAGES=2, MIN_ASSERT=1) share clock and
// reset. Edges are numbered from the first posedge after rst falls; outputs
// are sampled 1 time unit after each edge. The software-request steps are
// compiled in only when RST_SYNC_SEQ_SW_REQ_EN is defined.
// ----------------------------------------------------------------------------
module tb_rst_sync_seq;

    logic       clk;
    logic       rst;
`ifdef RST_SYNC_SEQ_SW_REQ_EN
    logic       swReq;
`endif
    logic [3:0] chRst;
    logic       allRel;
    logic       busyA;
    logic [0:0] chRstB;
    logic       allRelB;
    logic       busyB;

    int checks   = 0;
    int failures = 0;
    int edgeCnt  = 0;

    rst_sync_seq dut (
        .clk          (clk),
        .rst          (rst),
`ifdef RST_SYNC_SEQ_SW_REQ_EN
        .sw_rst_req   (swReq),
`endif
        .ch_rst_o     (chRst),
        .all_released (allRel),
        .busy         (busyA)
    );

    rst_sync_seq #(
        .NUM_CH      (1),
        .SYNC_STAGES (2),
        .MIN_ASSERT  (1),
        .RELEASE_GAP (8)
    ) dutSmall (
        .clk          (clk),
        .rst          (rst),
`ifdef RST_SYNC_SEQ_SW_REQ_EN
        .sw_rst_req   (swReq),
`endif
        .ch_rst_o     (chRstB),
        .all_released (allRelB),
        .busy         (busyB)
    );

    // 10-unit clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Advance to edge number n and settle 1 unit past it.
    task automatic applyStimulus(input int n);
        while (edgeCnt < n) begin
            @(posedge clk);
            edgeCnt++;
        end
        #1;
    endtask

    // Check the full output set of the default instance.
    task automatic checkMain(input string tag, input logic [3:0] ch, input logic all, input logic bsy);
        checkOutput({tag, "_ch"}, {4'h0, chRst}, {4'h0, ch});
        checkOutput({tag, "_all"}, {7'h0, allRel}, {7'h0, all});
        checkOutput({tag, "_busy"}, {7'h0, busyA}, {7'h0, bsy});
    endtask

    // Short asynchronous rst pulse mid-period, then renumber edges.
    task automatic shortResetPulse(input string tag);
        #3;
        rst = 1'b1;
        #1;
        checkMain({tag, "_async"}, 4'hF, 1'b0, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        checkMain({tag, "_afterpulse"}, 4'hF, 1'b0, 1'b1);
        edgeCnt = 0;
    endtask

    initial begin
        rst = 1'b1;
`ifdef RST_SYNC_SEQ_SW_REQ_EN
        swReq = 1'b0;
`endif
        #1;
        checkMain("reset", 4'hF, 1'b0, 1'b1);
        checkOutput("reset_small_ch", {7'h0, chRstB}, 8'h01);

        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        edgeCnt = 0;

        // Minimal configuration: release on edge 3.
        applyStimulus(2);
        checkOutput("small_e2_ch", {7'h0, chRstB}, 8'h01);
        checkOutput("small_e2_all", {7'h0, allRelB}, 8'h00);
        applyStimulus(3);
        checkOutput("small_e3_ch", {7'h0, chRstB}, 8'h00);
        checkOutput("small_e3_all", {7'h0, allRelB}, 8'h01);
        checkOutput("small_e3_busy", {7'h0, busyB}, 8'h00);

        // Default sequence: 19, 27, 35, 43.
        applyStimulus(18); checkMain("seq_e18", 4'hF, 1'b0, 1'b1);
        applyStimulus(19); checkMain("seq_e19", 4'hE, 1'b0, 1'b1);
        applyStimulus(26); checkMain("seq_e26", 4'hE, 1'b0, 1'b1);
        applyStimulus(27); checkMain("seq_e27", 4'hC, 1'b0, 1'b1);

        // rst pulse between edges 30 and 31.
        applyStimulus(30); checkMain("seq_e30", 4'hC, 1'b0, 1'b1);
        shortResetPulse("midrel");

        applyStimulus(18); checkMain("re_e18", 4'hF, 1'b0, 1'b1);
        applyStimulus(19); checkMain("re_e19", 4'hE, 1'b0, 1'b1);
        applyStimulus(27); checkMain("re_e27", 4'hC, 1'b0, 1'b1);
        applyStimulus(34); checkMain("re_e34", 4'hC, 1'b0, 1'b1);
        applyStimulus(35); checkMain("re_e35", 4'h8, 1'b0, 1'b1);
        applyStimulus(42); checkMain("re_e42", 4'h8, 1'b0, 1'b1);
        applyStimulus(43); checkMain("re_e43", 4'h0, 1'b1, 1'b0);

`ifdef RST_SYNC_SEQ_SW_REQ_EN
        // Software request in DONE, sampled at edge 60.
        applyStimulus(59);
        checkMain("done_e59", 4'h0, 1'b1, 1'b0);
        swReq = 1'b1;
        applyStimulus(60);
        swReq = 1'b0;
        checkMain("sw_e60", 4'hF, 1'b0, 1'b1);
        applyStimulus(75); checkMain("sw_e75", 4'hF, 1'b0, 1'b1);
        applyStimulus(76); checkMain("sw_e76", 4'hE, 1'b0, 1'b1);
        applyStimulus(99); checkMain("sw_e99", 4'h8, 1'b0, 1'b1);
        applyStimulus(100); checkMain("sw_e100", 4'h0, 1'b1, 1'b0);

        // Software request colliding with channel 1 release at edge 27.
        shortResetPulse("pre_coll");
        applyStimulus(26);
        checkMain("coll_e26", 4'hE, 1'b0, 1'b1);
        swReq = 1'b1;
        applyStimulus(27);
        swReq = 1'b0;
        checkMain("coll_e27", 4'hF, 1'b0, 1'b1);
        applyStimulus(42); checkMain("coll_e42", 4'hF, 1'b0, 1'b1);
        applyStimulus(43); checkMain("coll_e43", 4'hE, 1'b0, 1'b1);
        applyStimulus(51); checkMain("coll_e51", 4'hC, 1'b0, 1'b1);
`else
        // Without the request port the sequence stays in DONE.
        applyStimulus(60); checkMain("hold_e60", 4'h0, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
